lmi_watch_match: RTL and testbench



---
 rtl/lmi_watch_match.sv | 159 +++++++++++++++
 tb/tb_lmi_watch_match.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/lmi_watch_match.sv
// lmi_watch_match: two-channel LMI watchpoint matcher with pass counters, sticky hit status and break pulse; optional LMI_WATCH_MATCH_CAPTURE_EN adds trigger capture registers 9/10
module lmi_watch_match #(
    parameter int CNT_W = 16
) (
    input  logic        CLK,
    input  logic        RESET_D1_R_N,
    input  logic        LW_ISAMPLE_S,
    input  logic [31:0] LW_IADDR_S_R,
    input  logic        LW_DSAMPLE_W,
    input  logic        LW_DWRITE_W_R,
    input  logic [3:0]  LW_DBYEN_W_R,
    input  logic [31:0] LW_DADDR_W_R,
    input  logic [31:0] LW_DATA_W_R,
    input  logic        WM_CFG_WE,
    input  logic [3:0]  WM_CFG_ADDR,
    input  logic [31:0] WM_CFG_WDATA,
    output logic [31:0] WM_CFG_RDATA,
    output logic [1:0]  WM_HIT_R,
    output logic        WM_BREAK_R
);
    typedef enum logic [1:0] {DIS, ARM, TRG} st_t;
    localparam logic [31:0] CTRL_MASK = 32'h3f | (((32'h1 << CNT_W) - 32'h1) << 16);
    logic [31:0]      addr_q [2];
    logic [31:0]      mask_q [2];
    logic [31:0]      data_q [2];
    logic [31:0]      ctrl_q [2];
    st_t              st_q [2];
    st_t              st_d [2];
    logic [CNT_W-1:0] rem_q [2];
    logic [CNT_W-1:0] rem_d [2];
    logic [1:0]       cfg_sel, ctrl_wr, clr, im_m, dm_m, evt, trig_d, trig_q, hit_q;
    logic             trig_brk_d, trig_brk_q, brk_q, stat_wr, ch_r;

    function automatic logic data_ok(input logic [31:0] smp, input logic [31:0] cmp, input logic [3:0] byen);
        data_ok = 1'b1;
        for (int b = 0; b < 4; b++)
            if (byen[b] && smp[8*b +: 8] != cmp[8*b +: 8]) data_ok = 1'b0;
    endfunction

    assign stat_wr    = WM_CFG_WE && WM_CFG_ADDR == 4'd8;
    assign ch_r       = WM_CFG_ADDR[2];
    assign WM_HIT_R   = hit_q;
    assign WM_BREAK_R = brk_q;

    // per-channel compare of the current samples; a config write to the channel masks its event
    always_comb begin
        for (int c = 0; c < 2; c++) begin
            cfg_sel[c] = WM_CFG_WE && WM_CFG_ADDR[3:2] == 2'(c);
            ctrl_wr[c] = cfg_sel[c] && WM_CFG_ADDR[1:0] == 2'd3;
            clr[c]     = stat_wr && WM_CFG_WDATA[c];
            im_m[c]    = LW_ISAMPLE_S && ctrl_q[c][1] && ((LW_IADDR_S_R ^ addr_q[c]) & ~mask_q[c]) == 32'd0;
            dm_m[c]    = LW_DSAMPLE_W && (LW_DWRITE_W_R ? ctrl_q[c][3] : ctrl_q[c][2])
                         && ((LW_DADDR_W_R ^ addr_q[c]) & ~mask_q[c]) == 32'd0
                         && (!ctrl_q[c][4] || data_ok(LW_DATA_W_R, data_q[c], LW_DBYEN_W_R));
            evt[c]     = (im_m[c] || dm_m[c]) && !cfg_sel[c];
        end
    end

    // channel next state: CTRL writes dominate, then counting in ARM, then re-arm from TRG on status clear
    always_comb begin
        for (int c = 0; c < 2; c++) begin
            st_d[c]  = st_q[c];
            rem_d[c] = rem_q[c];
            if (ctrl_wr[c]) begin
                st_d[c]  = WM_CFG_WDATA[0] ? ARM : DIS;
                rem_d[c] = WM_CFG_WDATA[16 +: CNT_W];
            end else if (st_q[c] == ARM && evt[c]) begin
                if (rem_q[c] != '0) rem_d[c] = rem_q[c] - CNT_W'(1);
                else st_d[c] = TRG;
            end else if (st_q[c] == TRG && clr[c] && !trig_q[c] && ctrl_q[c][0]) begin
                st_d[c]  = ARM;
                rem_d[c] = ctrl_q[c][16 +: CNT_W];
            end
        end
    end

    // trigger strobes derived from the ARM->TRG transition
    always_comb begin
        for (int c = 0; c < 2; c++) trig_d[c] = st_q[c] == ARM && st_d[c] == TRG;
        trig_brk_d = |(trig_d & {ctrl_q[1][5], ctrl_q[0][5]});
    end

    // state, counters and the one-cycle trigger stage feeding sticky hit and break
    always_ff @(posedge CLK) begin
        if (!RESET_D1_R_N) begin
            for (int c = 0; c < 2; c++) begin
                st_q[c]  <= DIS;
                rem_q[c] <= '0;
            end
            trig_q     <= 2'b00;
            trig_brk_q <= 1'b0;
            hit_q      <= 2'b00;
            brk_q      <= 1'b0;
        end else begin
            for (int c = 0; c < 2; c++) begin
                st_q[c]  <= st_d[c];
                rem_q[c] <= rem_d[c];
            end
            trig_q     <= trig_d;
            trig_brk_q <= trig_brk_d;
            hit_q      <= (hit_q & ~clr) | trig_q;
            brk_q      <= trig_brk_q;
        end
    end

    // channel configuration registers
    always_ff @(posedge CLK) begin
        for (int c = 0; c < 2; c++) begin
            if (!RESET_D1_R_N) begin
                addr_q[c] <= 32'd0;
                mask_q[c] <= 32'd0;
                data_q[c] <= 32'd0;
                ctrl_q[c] <= 32'd0;
            end else if (cfg_sel[c]) begin
                if (WM_CFG_ADDR[1:0] == 2'd0) addr_q[c] <= WM_CFG_WDATA;
                if (WM_CFG_ADDR[1:0] == 2'd1) mask_q[c] <= WM_CFG_WDATA;
                if (WM_CFG_ADDR[1:0] == 2'd2) data_q[c] <= WM_CFG_WDATA;
                if (WM_CFG_ADDR[1:0] == 2'd3) ctrl_q[c] <= WM_CFG_WDATA & CTRL_MASK;
            end
        end
    end

`ifdef LMI_WATCH_MATCH_CAPTURE_EN
    logic [31:0] cap_addr_q, cap_info_q;
    logic        cap_im;
    assign cap_im = trig_d[0] ? im_m[0] : im_m[1];

    // first trigger's address/info held until STATUS is written; channel 0 wins ties
    always_ff @(posedge CLK) begin
        if (!RESET_D1_R_N) begin
            cap_addr_q <= 32'd0;
            cap_info_q <= 32'd0;
        end else if (|trig_d && (!cap_info_q[0] || stat_wr)) begin
            cap_addr_q <= cap_im ? LW_IADDR_S_R : LW_DADDR_W_R;
            cap_info_q <= {27'd0, LW_DWRITE_W_R, cap_im, |LW_DBYEN_W_R, !trig_d[0], 1'b1};
        end else if (stat_wr) begin
            cap_addr_q <= 32'd0;
            cap_info_q <= 32'd0;
        end
    end
`endif

    // combinational register read-back
    always_comb begin
        WM_CFG_RDATA = 32'd0;
        case (WM_CFG_ADDR)
            4'd0, 4'd4: WM_CFG_RDATA = addr_q[ch_r];
            4'd1, 4'd5: WM_CFG_RDATA = mask_q[ch_r];
            4'd2, 4'd6: WM_CFG_RDATA = data_q[ch_r];
            4'd3, 4'd7: WM_CFG_RDATA = ctrl_q[ch_r];
            4'd8:       WM_CFG_RDATA = {30'd0, hit_q};
`ifdef LMI_WATCH_MATCH_CAPTURE_EN
            4'd9:       WM_CFG_RDATA = cap_addr_q;
            4'd10:      WM_CFG_RDATA = cap_info_q;
`endif
            default:    WM_CFG_RDATA = 32'd0;
        endcase
    end
endmodule

// File: tb/tb_lmi_watch_match.sv
// tb_lmi_watch_match: directed-vector bench for lmi_watch_match
module tb_lmi_watch_match;
    logic        CLK = 1'b0;
    logic        RESET_D1_R_N = 1'b0;
    logic        LW_ISAMPLE_S = 1'b0;
    logic [31:0] LW_IADDR_S_R = 32'd0;
    logic        LW_DSAMPLE_W = 1'b0;
    logic        LW_DWRITE_W_R = 1'b0;
    logic [3:0]  LW_DBYEN_W_R = 4'd0;
    logic [31:0] LW_DADDR_W_R = 32'd0;
    logic [31:0] LW_DATA_W_R = 32'd0;
    logic        WM_CFG_WE = 1'b0;
    logic [3:0]  WM_CFG_ADDR = 4'd0;
    logic [31:0] WM_CFG_WDATA = 32'd0;
    logic [31:0] WM_CFG_RDATA;
    logic [1:0]  WM_HIT_R;
    logic        WM_BREAK_R;
    int          vectors = 0;
    int          miscompares = 0;

    lmi_watch_match #(.CNT_W(16)) dut (
        .CLK(CLK), .RESET_D1_R_N(RESET_D1_R_N),
        .LW_ISAMPLE_S(LW_ISAMPLE_S), .LW_IADDR_S_R(LW_IADDR_S_R),
        .LW_DSAMPLE_W(LW_DSAMPLE_W), .LW_DWRITE_W_R(LW_DWRITE_W_R),
        .LW_DBYEN_W_R(LW_DBYEN_W_R), .LW_DADDR_W_R(LW_DADDR_W_R), .LW_DATA_W_R(LW_DATA_W_R),
        .WM_CFG_WE(WM_CFG_WE), .WM_CFG_ADDR(WM_CFG_ADDR), .WM_CFG_WDATA(WM_CFG_WDATA),
        .WM_CFG_RDATA(WM_CFG_RDATA), .WM_HIT_R(WM_HIT_R), .WM_BREAK_R(WM_BREAK_R)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        WM_CFG_WE = 1'b1;
        WM_CFG_ADDR = a;
        WM_CFG_WDATA = d;
        tick();
        WM_CFG_WE = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [3:0] a, input logic [31:0] exp);
        WM_CFG_ADDR = a;
        #1;
        chk(tag, WM_CFG_RDATA, exp);
    endtask

    task automatic isamp(input logic [31:0] a);
        LW_ISAMPLE_S = 1'b1;
        LW_IADDR_S_R = a;
        tick();
        LW_ISAMPLE_S = 1'b0;
    endtask

    task automatic dsamp(input logic w, input logic [3:0] be, input logic [31:0] a, input logic [31:0] d);
        LW_DSAMPLE_W = 1'b1;
        LW_DWRITE_W_R = w;
        LW_DBYEN_W_R = be;
        LW_DADDR_W_R = a;
        LW_DATA_W_R = d;
        tick();
        LW_DSAMPLE_W = 1'b0;
    endtask

    initial begin
        tick();
        tick();
        chk("rst_hit", 32'(WM_HIT_R), 32'd0);
        chk("rst_brk", 32'(WM_BREAK_R), 32'd0);
        rd("rst_ctrl0", 4'd3, 32'd0);
        rd("rst_status", 4'd8, 32'd0);
        RESET_D1_R_N = 1'b1;
        tick();
        // channel 0: instruction watch on 0x1000 with break, preset 0
        wr(4'd0, 32'h1000);
        wr(4'd1, 32'h0);
        wr(4'd3, 32'h23);
        rd("ctrl0_rb", 4'd3, 32'h23);
        rd("addr0_rb", 4'd0, 32'h1000);
        isamp(32'h1004);
        tick();
        chk("imiss_hit", 32'(WM_HIT_R), 32'd0);
        isamp(32'h1000);
        chk("ihit_lat", 32'(WM_HIT_R), 32'd0);
        tick();
        chk("ihit_hit", 32'(WM_HIT_R), 32'd1);
        chk("ihit_brk", 32'(WM_BREAK_R), 32'd1);
        tick();
        chk("ihit_brk_end", 32'(WM_BREAK_R), 32'd0);
        chk("ihit_sticky", 32'(WM_HIT_R), 32'd1);
        rd("status_rb", 4'd8, 32'd1);
`ifdef LMI_WATCH_MATCH_CAPTURE_EN
        rd("cap_addr_i", 4'd9, 32'h1000);
        rd("cap_info_i", 4'd10, 32'h09);
`else
        wr(4'd9, 32'hDEADBEEF);
        rd("cap9_absent", 4'd9, 32'd0);
        rd("cap10_absent", 4'd10, 32'd0);
`endif
        wr(4'd8, 32'h0);
        chk("w1c_zero", 32'(WM_HIT_R), 32'd1);
        // channel 1: store watch 0x2000/0xFF with low-half data compare, preset 2, no break
        wr(4'd4, 32'h2000);
        wr(4'd5, 32'hFF);
        wr(4'd6, 32'h12345678);
        wr(4'd7, 32'h00020019);
        rd("ctrl1_rb", 4'd7, 32'h00020019);
        dsamp(1'b1, 4'b0011, 32'h2010, 32'hABCD5678);
        dsamp(1'b0, 4'b0011, 32'h2010, 32'hABCD5678);
        dsamp(1'b1, 4'b0011, 32'h2010, 32'hABCD0000);
        dsamp(1'b1, 4'b0011, 32'h2010, 32'hFFFF5678);
        tick();
        tick();
        chk("st_early", 32'(WM_HIT_R), 32'd1);
        dsamp(1'b1, 4'b0011, 32'h2010, 32'h00005678);
        tick();
        chk("st_hit", 32'(WM_HIT_R), 32'd3);
        chk("st_nobrk", 32'(WM_BREAK_R), 32'd0);
        tick();
        chk("st_nobrk2", 32'(WM_BREAK_R), 32'd0);
`ifdef LMI_WATCH_MATCH_CAPTURE_EN
        rd("cap_addr_d", 4'd9, 32'h2010);
        rd("cap_info_d", 4'd10, 32'h17);
`endif
        // channel 1 as load watch: stores ignored, loads trigger
        wr(4'd7, 32'h05);
        wr(4'd8, 32'h2);
        chk("clr1", 32'(WM_HIT_R), 32'd1);
        dsamp(1'b1, 4'b1111, 32'h2010, 32'h0);
        tick();
        tick();
        chk("dr_store_ign", 32'(WM_HIT_R), 32'd1);
        dsamp(1'b0, 4'b0000, 32'h2010, 32'h0);
        tick();
        tick();
        chk("dr_load_hit", 32'(WM_HIT_R), 32'd3);
        wr(4'd8, 32'h2);
        chk("clr1_again", 32'(WM_HIT_R), 32'd1);
        // status clear coinciding with a new channel 0 trigger
        wr(4'd3, 32'h23);
        isamp(32'h1000);
        wr(4'd8, 32'h1);
        chk("clr_vs_trig", 32'(WM_HIT_R), 32'd1);
        chk("clr_vs_trig_brk", 32'(WM_BREAK_R), 32'd1);
        tick();
        chk("clr_vs_trig_hold", 32'(WM_HIT_R), 32'd1);
        wr(4'd8, 32'h1);
        chk("clr_only", 32'(WM_HIT_R), 32'd0);
        // CTRL rewrite alongside a matching sample: event dropped, preset 1 reloaded
        LW_ISAMPLE_S = 1'b1;
        LW_IADDR_S_R = 32'h1000;
        wr(4'd3, 32'h00010023);
        LW_ISAMPLE_S = 1'b0;
        tick();
        chk("wr_vs_evt", 32'(WM_HIT_R), 32'd0);
        rd("ctrl0_cnt", 4'd3, 32'h00010023);
        isamp(32'h1000);
        tick();
        tick();
        chk("reload_cnt", 32'(WM_HIT_R), 32'd0);
        isamp(32'h1000);
        tick();
        chk("reload_trig", 32'(WM_HIT_R), 32'd1);
        chk("reload_brk", 32'(WM_BREAK_R), 32'd1);
        tick();
        // reset while triggered
        RESET_D1_R_N = 1'b0;
        tick();
        RESET_D1_R_N = 1'b1;
        chk("mid_rst_hit", 32'(WM_HIT_R), 32'd0);
        chk("mid_rst_brk", 32'(WM_BREAK_R), 32'd0);
        rd("mid_rst_status", 4'd8, 32'd0);
        rd("mid_rst_ctrl0", 4'd3, 32'd0);
        rd("mid_rst_ctrl1", 4'd7, 32'd0);
`ifdef LMI_WATCH_MATCH_CAPTURE_EN
        rd("mid_rst_cap", 4'd10, 32'd0);
`endif
        // reset right after a trigger discards the pending hit/break
        wr(4'd0, 32'h1000);
        wr(4'd3, 32'h23);
        isamp(32'h1000);
        RESET_D1_R_N = 1'b0;
        tick();
        RESET_D1_R_N = 1'b1;
        tick();
        chk("pend_rst_hit", 32'(WM_HIT_R), 32'd0);
        chk("pend_rst_brk", 32'(WM_BREAK_R), 32'd0);
        // out-of-map accesses
        wr(4'd12, 32'hFFFFFFFF);
        rd("oom12", 4'd12, 32'd0);
        rd("oom15", 4'd15, 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
